byte_write_packer: RTL and testbench



---
 rtl/byte_write_packer.sv | 161 ++++++++++++++++
 tb/tb_byte_write_packer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/byte_write_packer.sv
// Byte-write merger: collects single-byte writes that fall in the same 32-bit word
// and issues one registered four-lane write (we/wa/wd) per word.
module byte_write_packer #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LO  = 3,
  parameter int MEM_HI  = 250,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_data,
  input  logic              flush,
  output logic [3:0]        we,
  output logic [ADDR_W-3:0] wa,
  output logic [31:0]       wd,
  output logic              pending,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {S_EMPTY, S_PARTIAL} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-3:0] r_buf_wa, w_buf_wa_nxt;
  logic [3:0]        r_buf_m, w_buf_m_nxt;
  logic [31:0]       r_buf_d, w_buf_d_nxt;
  logic [CNT_W-1:0]  r_idle, w_idle_nxt;
  logic [3:0]        r_we, w_we_nxt;
  logic [ADDR_W-3:0] r_wa, w_wa_nxt;
  logic [31:0]       r_wd, w_wd_nxt;
  logic              r_err, w_err_nxt;

  logic              w_accept;
  logic              w_oor;
  logic              w_acc_legal;
  logic              w_acc_oor;
  logic [3:0]        w_lane_oh;
  logic [31:0]       w_byte_word;
  logic [ADDR_W-3:0] w_word;
  logic              w_same_word;
  logic              w_lane_hit;
  logic [3:0]        w_merged_m;
  logic [31:0]       w_merged_d;
  logic              w_tmo;

  assign in_ready    = ~flush;
  assign w_accept    = in_valid & in_ready;
  assign w_oor       = (in_addr < ADDR_W'(MEM_LO)) || (in_addr > ADDR_W'(MEM_HI));
  assign w_acc_legal = w_accept & ~w_oor;
  assign w_acc_oor   = w_accept & w_oor;
  assign w_word      = in_addr[ADDR_W-1:2];
  assign w_lane_oh   = 4'b0001 << in_addr[1:0];
  assign w_byte_word = {24'b0, in_data} << {in_addr[1:0], 3'b000};
  assign w_same_word = (w_word == r_buf_wa);
  assign w_lane_hit  = |(r_buf_m & w_lane_oh);
  assign w_merged_m  = r_buf_m | w_lane_oh;
  assign w_merged_d  = r_buf_d | w_byte_word;
  assign w_tmo       = (TIMEOUT > 0) && (r_idle == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_wa_nxt = r_buf_wa;
    w_buf_m_nxt  = r_buf_m;
    w_buf_d_nxt  = r_buf_d;
    w_idle_nxt   = r_idle;
    w_we_nxt     = 4'b0000;
    w_wa_nxt     = r_wa;
    w_wd_nxt     = r_wd;
    w_err_nxt    = r_err | w_acc_oor;

    unique case (r_state)
      S_EMPTY: begin
        if (w_acc_legal) begin
          w_buf_wa_nxt = w_word;
          w_buf_m_nxt  = w_lane_oh;
          w_buf_d_nxt  = w_byte_word;
          w_idle_nxt   = '0;
          w_state_nxt  = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (flush) begin
          w_we_nxt    = r_buf_m;
          w_wa_nxt    = r_buf_wa;
          w_wd_nxt    = r_buf_d;
          w_idle_nxt  = '0;
          w_state_nxt = S_EMPTY;
        end else if (w_acc_legal) begin
          w_idle_nxt = '0;
          if (w_same_word && !w_lane_hit) begin
            if (w_merged_m == 4'b1111) begin
              w_we_nxt    = 4'b1111;
              w_wa_nxt    = r_buf_wa;
              w_wd_nxt    = w_merged_d;
              w_state_nxt = S_EMPTY;
            end else begin
              w_buf_m_nxt = w_merged_m;
              w_buf_d_nxt = w_merged_d;
            end
          end else begin
            // Collision or word change: ship the old word, keep the new byte alone.
            w_we_nxt     = r_buf_m;
            w_wa_nxt     = r_buf_wa;
            w_wd_nxt     = r_buf_d;
            w_buf_wa_nxt = w_word;
            w_buf_m_nxt  = w_lane_oh;
            w_buf_d_nxt  = w_byte_word;
          end
        end else if (w_acc_oor) begin
          w_idle_nxt = r_idle;
        end else if (w_tmo) begin
          w_we_nxt    = r_buf_m;
          w_wa_nxt    = r_buf_wa;
          w_wd_nxt    = r_buf_d;
          w_idle_nxt  = '0;
          w_state_nxt = S_EMPTY;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Stage boundary: control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_idle  <= '0;
      r_we    <= 4'b0000;
      r_wa    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_we    <= w_we_nxt;
      r_wa    <= w_wa_nxt;
      r_wd    <= w_wd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Buffer contents are only meaningful in PARTIAL, so they carry no reset.
  always_ff @(posedge clk) begin
    r_buf_wa <= w_buf_wa_nxt;
    r_buf_m  <= w_buf_m_nxt;
    r_buf_d  <= w_buf_d_nxt;
  end

  assign we      = r_we;
  assign wa      = r_wa;
  assign wd      = r_wd;
  assign pending = (r_state == S_PARTIAL);
  assign err     = r_err;

endmodule

// File: tb/tb_byte_write_packer.sv
// Directed table-driven bench for byte_write_packer, plus hand-written timeout
// and ready sequences.
module tb_byte_write_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_addr = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       flush = 1'b0;
  logic [3:0] we;
  logic [5:0] wa;
  logic [31:0] wd;
  logic       pending;
  logic       err;

  int checks = 0;
  int failures = 0;

  byte_write_packer #(.ADDR_W(8), .MEM_LO(3), .MEM_HI(250), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .flush(flush),
    .we(we), .wa(wa), .wd(wd), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        flush;
    logic [3:0]  we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        pend;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] a, input logic [7:0] d,
                     input logic f, input logic [3:0] ew, input logic [5:0] ea,
                     input logic [31:0] ed, input logic ep, input logic ee);
    vec_t t;
    t.rst = r; t.vld = v; t.addr = a; t.data = d; t.flush = f;
    t.we = ew; t.wa = ea; t.wd = ed; t.pend = ep; t.err = ee;
    vecs.push_back(t);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    int cyc;
    // rst vld addr data flush | we wa wd pend err
    add(1, 0, 0,   8'h00, 0, 4'b0000, 0, 32'h0,        0, 0);
    add(0, 1, 5,   8'h12, 0, 4'b0000, 0, 32'h0,        1, 0);
    add(0, 1, 6,   8'h34, 0, 4'b0000, 0, 32'h0,        1, 0);
    add(0, 1, 7,   8'h56, 0, 4'b0000, 0, 32'h0,        1, 0);
    add(0, 0, 0,   8'h00, 1, 4'b1110, 1, 32'h56341200, 0, 0);
    add(0, 0, 0,   8'h00, 0, 4'b0000, 1, 32'h56341200, 0, 0);
    add(0, 1, 8,   8'hAA, 0, 4'b0000, 1, 32'h56341200, 1, 0);
    add(0, 1, 9,   8'hBB, 0, 4'b0000, 1, 32'h56341200, 1, 0);
    add(0, 1, 10,  8'hCC, 0, 4'b0000, 1, 32'h56341200, 1, 0);
    add(0, 1, 11,  8'hDD, 0, 4'b1111, 2, 32'hDDCCBBAA, 0, 0);
    add(0, 0, 0,   8'h00, 0, 4'b0000, 2, 32'hDDCCBBAA, 0, 0);
    add(0, 1, 12,  8'h11, 0, 4'b0000, 2, 32'hDDCCBBAA, 1, 0);
    add(0, 1, 12,  8'h22, 0, 4'b0001, 3, 32'h00000011, 1, 0);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 8'h00, 0, 4'b0000, 3, 32'h00000011, 1, 0);
    add(0, 0, 0,   8'h00, 0, 4'b0001, 3, 32'h00000022, 0, 0);
    add(0, 1, 13,  8'h01, 0, 4'b0000, 3, 32'h00000022, 1, 0);
    add(0, 1, 20,  8'h02, 0, 4'b0010, 3, 32'h00000100, 1, 0);
    add(0, 0, 0,   8'h00, 1, 4'b0001, 5, 32'h00000002, 0, 0);
    add(0, 1, 16,  8'h77, 0, 4'b0000, 5, 32'h00000002, 1, 0);
    add(0, 1, 2,   8'h99, 0, 4'b0000, 5, 32'h00000002, 1, 1);
    add(0, 1, 251, 8'hAB, 0, 4'b0000, 5, 32'h00000002, 1, 1);
    add(0, 0, 0,   8'h00, 1, 4'b0001, 4, 32'h00000077, 0, 1);
    add(0, 1, 255, 8'hCD, 0, 4'b0000, 4, 32'h00000077, 0, 1);
    add(0, 1, 3,   8'h33, 0, 4'b0000, 4, 32'h00000077, 1, 1);
    add(0, 0, 0,   8'h00, 1, 4'b1000, 0, 32'h33000000, 0, 1);
    add(0, 1, 250, 8'h44, 0, 4'b0000, 0, 32'h33000000, 1, 1);
    add(0, 0, 0,   8'h00, 1, 4'b0100, 62, 32'h00440000, 0, 1);
    add(0, 0, 0,   8'h00, 1, 4'b0000, 62, 32'h00440000, 0, 1);
    add(0, 1, 8,   8'h55, 0, 4'b0000, 62, 32'h00440000, 1, 1);
    add(0, 1, 9,   8'h66, 1, 4'b0001, 2, 32'h00000055, 0, 1);
    add(0, 0, 0,   8'h00, 0, 4'b0000, 2, 32'h00000055, 0, 1);
    add(0, 1, 4,   8'hA1, 0, 4'b0000, 2, 32'h00000055, 1, 1);
    add(0, 1, 5,   8'hA2, 0, 4'b0000, 2, 32'h00000055, 1, 1);
    add(0, 1, 6,   8'hA3, 0, 4'b0000, 2, 32'h00000055, 1, 1);
    add(1, 0, 0,   8'h00, 0, 4'b0000, 0, 32'h0,        0, 0);
    add(0, 0, 0,   8'h00, 1, 4'b0000, 0, 32'h0,        0, 0);
    add(0, 0, 0,   8'h00, 0, 4'b0000, 0, 32'h0,        0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].vld; in_addr = vecs[i].addr;
      in_data = vecs[i].data; flush = vecs[i].flush;
      @(posedge clk);
      #1;
      checks++;
      if (we !== vecs[i].we || wa !== vecs[i].wa || wd !== vecs[i].wd ||
          pending !== vecs[i].pend || err !== vecs[i].err) begin
        failures++;
        $display("FAIL vec%0d we/wa/wd/pend/err got %b/%0d/%h/%b/%b want %b/%0d/%h/%b/%b",
                 i, we, wa, wd, pending, err,
                 vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pend, vecs[i].err);
      end
    end

    // in_ready follows ~flush combinationally.
    rst = 0; in_valid = 0; flush = 1;
    #1 check1("ready_flush_hi", {31'b0, in_ready}, 32'd0);
    flush = 0;
    #1 check1("ready_flush_lo", {31'b0, in_ready}, 32'd1);

    // Timeout sequence: a lone byte must auto-flush on the 8th idle edge.
    @(posedge clk); #1;
    in_valid = 1; in_addr = 8'd33; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 0;
    check1("tmo_pending", {31'b0, pending}, 32'd1);
    cyc = 0;
    while (we == 4'b0000 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check1("tmo_cycles", cyc, 32'd8);
    check1("tmo_we", {28'b0, we}, 32'h2);
    check1("tmo_wa", {26'b0, wa}, 32'd8);
    check1("tmo_wd", wd, 32'h00005A00);
    @(posedge clk); #1;
    check1("tmo_we_pulse", {28'b0, we}, 32'h0);
    check1("tmo_pending_clr", {31'b0, pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
